// File: rtl/d_hazard_ctrl.sv
// Decode-stage hazard controller: load-use detection, MDU busy-window sequencing,
// and the stall/flush controls for the F, D and E stages.
module d_hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int REG_W   = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [REG_W-1:0] i_rsD,
    input  logic [REG_W-1:0] i_rtD,
    input  logic             i_use_rtD,
    input  logic [REG_W-1:0] i_rtE,
    input  logic             i_memreadE,
    input  logic             i_branch_takenD,
    input  logic             i_mdu_startD,
    input  logic             i_mfhiloD,
    output logic             o_stallF,
    output logic             o_stallD,
    output logic             o_flushD,
    output logic             o_flushE,
    output logic             o_mdu_issue,
    output logic             o_mdu_busy,
    output logic [2:0]       o_mdu_cnt
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [2:0] LAT_CNT = 3'(MDU_LAT);

    state_t     state;
    logic [2:0] cnt;

    logic rs_hit;
    logic rt_hit;
    logic lu;
    logic md;
    logic stall;
    logic issue;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    always_comb begin
        rs_hit = (i_rtE == i_rsD);
        rt_hit = i_use_rtD & (i_rtE == i_rtD);
        lu     = i_memreadE & (i_rtE != '0) & (rs_hit | rt_hit);
        md     = (state == BUSY) & (i_mdu_startD | i_mfhiloD);
        stall  = lu | md;
        issue  = i_mdu_startD & ~stall;
    end

    // A new mul/div can only issue from IDLE: md holds it off until cnt has drained.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (issue) begin
            state <= BUSY;
            cnt   <= LAT_CNT;
        end else if (cnt != '0) begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) begin
                state <= IDLE;
            end
        end
    end

    always_comb begin
        o_stallF    = 1'b0;
        o_stallD    = 1'b0;
        o_flushE    = 1'b0;
        o_flushD    = 1'b0;
        o_mdu_issue = 1'b0;
        o_mdu_busy  = 1'b0;
        o_mdu_cnt   = '0;
        if (!i_rst) begin
            o_stallF    = stall;
            o_stallD    = stall;
            o_flushE    = stall;
            o_flushD    = i_branch_takenD & ~stall;
            o_mdu_issue = issue;
            o_mdu_busy  = (state == BUSY);
            o_mdu_cnt   = cnt;
        end
    end

endmodule

// File: tb/tb_d_hazard_ctrl.sv
// Bench for d_hazard_ctrl: vector table, hand-written multi-cycle sequences and
// random stimulus against a cycle-level reference model.
module tb_d_hazard_ctrl;

    localparam int MDU_LAT = 4;
    localparam int REG_W   = 5;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic [REG_W-1:0] i_rsD, i_rtD, i_rtE;
    logic             i_use_rtD, i_memreadE, i_branch_takenD, i_mdu_startD, i_mfhiloD;
    logic             o_stallF, o_stallD, o_flushD, o_flushE, o_mdu_issue, o_mdu_busy;
    logic [2:0]       o_mdu_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model: number of MDU cycles still outstanding.
    int m_remaining = 0;
    bit m_issue;

    d_hazard_ctrl #(.MDU_LAT(MDU_LAT), .REG_W(REG_W)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_rsD          (i_rsD),
        .i_rtD          (i_rtD),
        .i_use_rtD      (i_use_rtD),
        .i_rtE          (i_rtE),
        .i_memreadE     (i_memreadE),
        .i_branch_takenD(i_branch_takenD),
        .i_mdu_startD   (i_mdu_startD),
        .i_mfhiloD      (i_mfhiloD),
        .o_stallF       (o_stallF),
        .o_stallD       (o_stallD),
        .o_flushD       (o_flushD),
        .o_flushE       (o_flushE),
        .o_mdu_issue    (o_mdu_issue),
        .o_mdu_busy     (o_mdu_busy),
        .o_mdu_cnt      (o_mdu_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [REG_W-1:0] rsD, rtD, rtE;
        logic use_rt, memE, br, start, mfhi;
        logic e_stall, e_flushD, e_issue;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        i_rsD = '0; i_rtD = '0; i_rtE = '0;
        i_use_rtD = 0; i_memreadE = 0; i_branch_takenD = 0;
        i_mdu_startD = 0; i_mfhiloD = 0;
    endtask

    // Expected outputs derived directly from the hazard rules, then compared.
    task automatic check_model(input string tag);
        bit lu, md, st, fd, busy;
        int c;
        lu = i_memreadE && (i_rtE != 0) &&
             ((i_rtE == i_rsD) || (i_use_rtD && (i_rtE == i_rtD)));
        md = (m_remaining > 0) && (i_mdu_startD || i_mfhiloD);
        st = lu || md;
        fd = i_branch_takenD && !st;
        m_issue = i_mdu_startD && !st;
        busy = (m_remaining > 0);
        c = m_remaining;
        if (i_rst) begin
            st = 0; fd = 0; busy = 0; c = 0;
        end
        chk({tag, ".stallF"}, o_stallF, st);
        chk({tag, ".stallD"}, o_stallD, st);
        chk({tag, ".flushE"}, o_flushE, st);
        chk({tag, ".flushD"}, o_flushD, fd);
        chk({tag, ".issue"},  o_mdu_issue, (m_issue && !i_rst));
        chk({tag, ".busy"},   o_mdu_busy, busy);
        chk({tag, ".cnt"},    o_mdu_cnt, c);
    endtask

    // Caller has set inputs after a falling edge and waited #1.
    task automatic step(input string tag);
        check_model(tag);
        @(posedge i_clk);
        if (i_rst)             m_remaining = 0;
        else if (m_issue)      m_remaining = MDU_LAT;
        else if (m_remaining > 0) m_remaining--;
        @(negedge i_clk);
    endtask

    initial begin
        vecs[0]  = '{8, 0, 8, 0, 1, 0, 0, 0, 1, 0, 0};  // rs match
        vecs[1]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};  // r0 load
        vecs[2]  = '{1, 9, 9, 0, 1, 0, 0, 0, 0, 0, 0};  // rt match, rt unused
        vecs[3]  = '{1, 9, 9, 1, 1, 0, 0, 0, 1, 0, 0};  // rt match, rt used
        vecs[4]  = '{8, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0};  // not a load
        vecs[5]  = '{3, 4, 5, 1, 1, 1, 0, 0, 0, 1, 0};  // branch, no hazard
        vecs[6]  = '{5, 4, 5, 1, 1, 1, 0, 0, 1, 0, 0};  // branch under lu
        vecs[7]  = '{3, 4, 5, 1, 1, 0, 1, 0, 0, 0, 1};  // mult issues
        vecs[8]  = '{5, 4, 5, 0, 1, 0, 1, 0, 1, 0, 0};  // mult under lu
        vecs[9]  = '{2, 3, 4, 0, 0, 0, 0, 1, 0, 0, 0};  // mfhi while idle
        vecs[10] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};  // r0 via rt

        idle();
        i_rst = 1;
        i_mdu_startD = 1; i_memreadE = 1; i_rtE = 8; i_rsD = 8; i_branch_takenD = 1;
        @(negedge i_clk); #1;
        chk("rst.stallF", o_stallF, 0);
        chk("rst.flushD", o_flushD, 0);
        chk("rst.issue",  o_mdu_issue, 0);
        step("rst");
        idle();
        i_rst = 0; #1;
        chk("post_rst.busy", o_mdu_busy, 0);
        chk("post_rst.cnt",  o_mdu_cnt, 0);
        step("post_rst");

        // Table vectors, each applied from IDLE with a reset cycle between.
        for (int k = 0; k < 11; k++) begin
            i_rsD = vecs[k].rsD; i_rtD = vecs[k].rtD; i_rtE = vecs[k].rtE;
            i_use_rtD = vecs[k].use_rt; i_memreadE = vecs[k].memE;
            i_branch_takenD = vecs[k].br; i_mdu_startD = vecs[k].start;
            i_mfhiloD = vecs[k].mfhi;
            #1;
            chk($sformatf("vec%0d.stallF", k), o_stallF, vecs[k].e_stall);
            chk($sformatf("vec%0d.stallD", k), o_stallD, vecs[k].e_stall);
            chk($sformatf("vec%0d.flushE", k), o_flushE, vecs[k].e_stall);
            chk($sformatf("vec%0d.flushD", k), o_flushD, vecs[k].e_flushD);
            chk($sformatf("vec%0d.issue", k),  o_mdu_issue, vecs[k].e_issue);
            step($sformatf("vec%0d", k));
            idle(); i_rst = 1; #1;
            step("vec_rst");
            i_rst = 0;
        end

        // Load-use lasts one cycle: the bubble then sits in E.
        idle(); i_memreadE = 1; i_rtE = 8; i_rsD = 8; #1;
        chk("lu1.stall", o_stallD, 1);
        step("lu1");
        i_memreadE = 0; i_rtE = 0; #1;
        chk("lu2.stall", o_stallD, 0);
        step("lu2");

        // mult at t, mflo from t+2, then a second mult once the unit drains.
        idle(); i_mdu_startD = 1; #1;
        chk("mdu_t.issue", o_mdu_issue, 1);
        chk("mdu_t.busy",  o_mdu_busy, 0);
        step("mdu_t");
        idle(); #1;
        chk("mdu_t1.cnt", o_mdu_cnt, 4);
        chk("mdu_t1.busy", o_mdu_busy, 1);
        step("mdu_t1");
        for (int k = 0; k < 3; k++) begin
            idle(); i_mfhiloD = 1; #1;
            chk($sformatf("mdu_t%0d.cnt", k + 2), o_mdu_cnt, 3 - k);
            chk($sformatf("mdu_t%0d.stallF", k + 2), o_stallF, 1);
            chk($sformatf("mdu_t%0d.flushE", k + 2), o_flushE, 1);
            step($sformatf("mdu_t%0d", k + 2));
        end
        idle(); i_mfhiloD = 1; #1;
        chk("mdu_t5.busy", o_mdu_busy, 0);
        chk("mdu_t5.stall", o_stallD, 0);
        step("mdu_t5");
        idle(); i_mdu_startD = 1; #1;
        chk("mdu_re.issue", o_mdu_issue, 1);
        step("mdu_re");
        idle(); #1;
        chk("mdu_re.cnt", o_mdu_cnt, 4);
        step("mdu_re1");
        step("mdu_re2");

        // cnt is 2: reset with hazards present on the inputs.
        chk("rstmid.cnt_before", o_mdu_cnt, 2);
        i_rst = 1; i_mfhiloD = 1; i_memreadE = 1; i_rtE = 8; i_rsD = 8; #1;
        chk("rstmid.stall", o_stallD, 0);
        chk("rstmid.busy",  o_mdu_busy, 0);
        step("rstmid");
        i_rst = 0; idle(); i_mfhiloD = 1; #1;
        chk("rstmid.cnt_after", o_mdu_cnt, 0);
        chk("rstmid.stall_after", o_stallD, 0);
        step("rstmid_after");

        // Taken branch coincident with load-use, re-evaluated next cycle.
        idle(); i_branch_takenD = 1; i_memreadE = 1; i_rtE = 7; i_rtD = 7; i_use_rtD = 1; #1;
        chk("br_lu.flushD", o_flushD, 0);
        chk("br_lu.stall",  o_stallF, 1);
        step("br_lu");
        i_memreadE = 0; i_rtE = 0; #1;
        chk("br_next.flushD", o_flushD, 1);
        step("br_next");

        // Random stimulus with a narrow register range to provoke matches.
        for (int n = 0; n < 600; n++) begin
            i_rst           = ($urandom_range(0, 29) == 0);
            i_rsD           = REG_W'($urandom_range(0, 3));
            i_rtD           = REG_W'($urandom_range(0, 3));
            i_rtE           = REG_W'($urandom_range(0, 3));
            i_use_rtD       = 1'($urandom_range(0, 1));
            i_memreadE      = ($urandom_range(0, 2) == 0);
            i_branch_takenD = ($urandom_range(0, 3) == 0);
            i_mdu_startD    = ($urandom_range(0, 3) == 0);
            i_mfhiloD       = ($urandom_range(0, 3) == 0);
            #1;
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
